// File: rtl/btn_conditioner_if.sv
// btn_conditioner_if: groups the button-conditioner data signals.
//   btn_in        raw, asynchronous, possibly bouncing button
//   btn_level     debounced button level
//   press_pulse   one-cycle strobe on an accepted press
//   release_pulse one-cycle strobe on an accepted release
//   press_count   accepted presses, modulo 256
// master: the side that owns the button and consumes the results.
// slave:  the conditioner itself.
interface btn_conditioner_if;
    logic       btn_in;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic [7:0] press_count;

    modport master (
        output btn_in,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  press_count
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output press_count
    );
endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronises and debounces a push-button.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of btn_conditioner_if:
//            btn_in (in), btn_level, press_pulse, release_pulse, press_count (out)
// A level change is accepted only after DEBOUNCE_CYCLES consecutive stable samples
// following entry into a check state. All outputs are registered.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst_n,
    btn_conditioner_if.slave    bus
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPressChk,
        StPressed,
        StReleaseChk
    } state_t;

    state_t        state_q;
    logic          s1_q;
    logic          s2_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q              <= 1'b0;
            s2_q              <= 1'b0;
            state_q           <= StIdle;
            cnt_q             <= '0;
            bus.btn_level     <= 1'b0;
            bus.press_pulse   <= 1'b0;
            bus.release_pulse <= 1'b0;
            bus.press_count   <= 8'd0;
        end else begin
            s1_q              <= bus.btn_in;
            s2_q              <= s1_q;
            // Strobes default low; only a check-state completion raises one.
            bus.press_pulse   <= 1'b0;
            bus.release_pulse <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (s2_q) begin
                        state_q <= StPressChk;
                        cnt_q   <= '0;
                    end
                end
                StPressChk: begin
                    if (!s2_q) begin
                        // Bounce: drop back and start the window over next time.
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q         <= StPressed;
                        cnt_q           <= '0;
                        bus.btn_level   <= 1'b1;
                        bus.press_pulse <= 1'b1;
                        bus.press_count <= bus.press_count + 8'd1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StPressed: begin
                    if (!s2_q) begin
                        state_q <= StReleaseChk;
                        cnt_q   <= '0;
                    end
                end
                StReleaseChk: begin
                    if (s2_q) begin
                        state_q <= StPressed;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q           <= StIdle;
                        cnt_q             <= '0;
                        bus.btn_level     <= 1'b0;
                        bus.release_pulse <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

    localparam int unsigned DEB = 4;

    logic clk;
    logic rst_n;

    btn_conditioner_if bus ();

    btn_conditioner #(
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         press;
        int         cyc;
        logic [7:0] count;
    } exp_t;

    exp_t       sb[$];
    int         checks;
    int         errors;
    int         cyc;
    int         n_press;
    int         n_release;
    logic       exp_level;
    logic [7:0] exp_count;

    // Advance one clock edge, then compare any strobe against the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() != 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_strobe: at cycle %0d got none, required %s at cycle %0d",
                     cyc, sb[0].press ? "press" : "release", sb[0].cyc);
            exp_level = sb[0].press;
            void'(sb.pop_front());
        end
        if (bus.press_pulse || bus.release_pulse) begin
            checks++;
            if (bus.press_pulse) n_press++;
            if (bus.release_pulse) n_release++;
            if (bus.press_pulse && bus.release_pulse) begin
                errors++;
                $display("FAIL both_strobes: cycle %0d press=1 release=1, required not both", cyc);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: cycle %0d press=%0b release=%0b, required none",
                         cyc, bus.press_pulse, bus.release_pulse);
            end else begin
                e = sb.pop_front();
                if (e.press !== bus.press_pulse || e.cyc != cyc || e.count !== bus.press_count) begin
                    errors++;
                    $display("FAIL strobe: got press=%0b cyc=%0d count=%0d, required press=%0b cyc=%0d count=%0d",
                             bus.press_pulse, cyc, bus.press_count, e.press, e.cyc, e.count);
                end
                exp_level = e.press;
            end
        end
        checks++;
        if (bus.btn_level !== exp_level) begin
            errors++;
            $display("FAIL level: cycle %0d got %0b, required %0b", cyc, bus.btn_level, exp_level);
        end
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        bus.btn_in = 1'b0;
        sb.delete();
        exp_level  = 1'b0;
        exp_count  = 8'd0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (4) step();
    endtask

    // Raise the button (first sampled at the next edge) and hold it.
    task automatic do_press(input int hold);
        exp_t e;
        bus.btn_in = 1'b1;
        exp_count  = exp_count + 8'd1;
        e.press    = 1'b1;
        e.cyc      = cyc + 1 + DEB + 2;
        e.count    = exp_count;
        sb.push_back(e);
        repeat (hold) step();
    endtask

    task automatic do_release(input int hold);
        exp_t e;
        bus.btn_in = 1'b0;
        e.press    = 1'b0;
        e.cyc      = cyc + 1 + DEB + 2;
        e.count    = exp_count;
        sb.push_back(e);
        repeat (hold) step();
    endtask

    task automatic check_idle_state(input string name, input logic [7:0] count);
        checks++;
        if (sb.size() != 0 || bus.press_count !== count) begin
            errors++;
            $display("FAIL %s: count=%0d pending=%0d, required count=%0d pending=0",
                     name, bus.press_count, sb.size(), count);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.btn_in = 1'b0;
        exp_level  = 1'b0;
        exp_count  = 8'd0;
        for (int i = 0; i < 8; i++) begin
            bus.btn_in = i[0];
            step();
            checks++;
            if ({bus.btn_level, bus.press_pulse, bus.release_pulse, bus.press_count} !== 11'd0) begin
                errors++;
                $display("FAIL reset_hold: lvl=%0b pp=%0b rp=%0b cnt=%0d, required all 0",
                         bus.btn_level, bus.press_pulse, bus.release_pulse, bus.press_count);
            end
        end
        bus.btn_in = 1'b0;
        rst_n      = 1'b1;
        repeat (20) step();
        check_idle_state("reset_release", 8'd0);
    endtask

    task automatic test_press_release();
        do_press(20);
        check_idle_state("press_count_1", 8'd1);
        do_release(20);
        check_idle_state("after_release", 8'd1);
    endtask

    task automatic test_bounce();
        logic [6:0] pat;
        pat = 7'b1101101;
        for (int i = 6; i >= 0; i--) begin
            bus.btn_in = pat[i];
            step();
        end
        bus.btn_in = 1'b0;
        repeat (10) step();
        check_idle_state("bounce_idle", 8'd1);
        do_press(12);
        for (int i = 6; i >= 0; i--) begin
            bus.btn_in = pat[i];
            step();
        end
        bus.btn_in = 1'b1;
        repeat (10) step();
        checks++;
        if (bus.btn_level !== 1'b1 || n_release != 1) begin
            errors++;
            $display("FAIL bounce_pressed: level=%0b releases=%0d, required level=1 releases=1",
                     bus.btn_level, n_release);
        end
        do_release(12);
        check_idle_state("bounce_done", 8'd2);
    endtask

    task automatic test_restart();
        bus.btn_in = 1'b1;
        repeat (3) step();
        bus.btn_in = 1'b0;
        step();
        do_press(12);
        check_idle_state("restart_press", 8'd3);
        do_release(12);
    endtask

    task automatic test_wrap();
        int p0;
        int r0;
        apply_reset();
        p0 = n_press;
        r0 = n_release;
        for (int i = 1; i <= 257; i++) begin
            do_press(8);
            if (i == 255 || i == 256 || i == 257) begin
                checks++;
                if (bus.press_count !== exp_count) begin
                    errors++;
                    $display("FAIL wrap_count_%0d: got %0d, required %0d", i, bus.press_count, exp_count);
                end
            end
            do_release(8);
        end
        checks++;
        if (n_press - p0 != 257 || n_release - r0 != 257 || exp_count !== 8'd1) begin
            errors++;
            $display("FAIL wrap_strobes: presses=%0d releases=%0d, required 257 and 257",
                     n_press - p0, n_release - r0);
        end
        check_idle_state("wrap_final", 8'd1);
    endtask

    task automatic test_mid_reset();
        exp_t e;
        bus.btn_in = 1'b1;
        repeat (5) step();   // two cycles into the press check
        rst_n     = 1'b0;
        exp_count = 8'd0;
        repeat (3) step();
        checks++;
        if ({bus.btn_level, bus.press_pulse, bus.release_pulse, bus.press_count} !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset: lvl=%0b pp=%0b rp=%0b cnt=%0d, required all 0",
                     bus.btn_level, bus.press_pulse, bus.release_pulse, bus.press_count);
        end
        rst_n     = 1'b1;
        exp_count = 8'd1;
        e.press   = 1'b1;
        e.cyc     = cyc + 1 + DEB + 2;
        e.count   = 8'd1;
        sb.push_back(e);
        repeat (10) step();
        check_idle_state("mid_reset_count", 8'd1);
        do_release(12);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        n_press   = 0;
        n_release = 0;
        rst_n      = 1'b0;
        bus.btn_in = 1'b0;
        exp_level  = 1'b0;
        exp_count  = 8'd0;
        test_reset();
        test_press_release();
        test_bounce();
        test_restart();
        test_wrap();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
